song_play_ctrl: RTL
===================

Name: song_play_ctrl

Overview:
Playback controller that sequences the per-song note ROM/lookup blocks in the synth board.
- Generates a single-cycle beat enable from clk50 and a note index, replacing any derived slow clock.
- Provides play/pause/stop/next transport and selects one of NSONGS songs sharing the tone output.
- Downstream song blocks decode note_idx when song_sel matches; the output mux gates tone with mute.

Parameters:
NSONGS, 4, number of selectable songs (2..8)
IDXW, 10, width of note index and song-length fields
GAP_BEATS, 8, silent beats between songs in auto-advance mode
TDW, 24, width of tempo divider

Ports:
clk50  in  1  50 MHz system clock
reset  in  1  asynchronous, active-low reset
btn_play  in  1  raw level, play/pause toggle
btn_stop  in  1  raw level, stop
btn_next  in  1  raw level, next song
loop_en  in  1  repeat current song at end
auto_adv  in  1  advance to next song after gap at end (ignored if loop_en)
tempo_div  in  TDW  clk50 cycles per beat; values <2 treated as 2
song_len  in  NSONGS*IDXW  per-song last note index, song k at [k*IDXW +: IDXW]; 0 treated as 1
song_sel  out  log2(NSONGS) (min 1)  active song
note_idx  out  IDXW  current note, 0 = rest
beat_tick  out  1  one-cycle pulse per beat
playing  out  1  state==PLAY
mute  out  1  1 unless state==PLAY
song_done  out  1  one-cycle pulse at end of song when not looping

Behaviour:
- Reset values: state IDLE, song_sel 0, note_idx 0, beat_tick 0, playing 0, mute 1, song_done 0, tick counter 0.
- Buttons: each goes through a 2-FF synchronizer and rising-edge detect, giving a one-cycle cmd pulse 3 cycles after the raw edge. Holding a button gives only one pulse.
- Command priority on the same cycle: stop > next > play.
- Tick counter runs only in PLAY and GAP; it holds in PAUSE and is cleared in IDLE.
  - Counts 0..T-1, where T = max(tempo_div, 2). At count T-1, beat_tick=1 and the counter wraps to 0.
  - tempo_div is sampled into T only at wrap or on entry to PLAY.
- States: IDLE, PLAY, PAUSE, GAP.
- IDLE:
  - play -> PLAY, note_idx=1, counter=0.
  - next -> song_sel+1 mod NSONGS, stays IDLE.
- PLAY:
  - play -> PAUSE; note_idx and counter are held.
  - On beat_tick with note_idx < L (L = effective song_len[song_sel]): note_idx+1.
  - On beat_tick with note_idx >= L:
    - if loop_en: note_idx=1.
    - else: song_done=1 and note_idx=0; then GAP if auto_adv, else IDLE.
- PAUSE: play -> PLAY, resuming the held counter and note_idx.
- GAP:
  - Counts GAP_BEATS beat_ticks with note_idx=0.
  - On the last tick: song_sel+1 mod NSONGS, note_idx=1, PLAY.
  - GAP_BEATS=0 goes straight to PLAY on the next cycle.
- next in PLAY/PAUSE/GAP: song_sel+1 mod NSONGS, note_idx=1, counter=0, state PLAY.
- stop in any state: IDLE, note_idx=0, counter=0; song_sel is kept.
- song_len change mid-song: if note_idx is already > new L, the end-of-song branch fires on the next beat_tick.
- All outputs are registered; mute/playing update in the same cycle as the state register.
- Reset is asynchronous mid-operation and returns everything to reset values.

Decomposition:
- Shared package song_pkg: state encoding (IDLE=0, PLAY=1, PAUSE=2, GAP=3), IDXW, TDW, and the REST index 0 constant, all reused by the song note blocks.
- One sub-module btn_edge: 2-FF sync plus rising-edge pulse, instantiated three times.

Test Plan:
1. Basic play:
   - Stimulus: tempo_div=4, song_len[0]=3, loop_en=0, auto_adv=0, press play.
   - Required: note_idx 1,2,3 each held 4 cycles; beat_tick every 4th cycle; song_done pulses on the 3rd tick; note_idx 0; IDLE; mute=1.
2. Loop:
   - Stimulus: loop_en=1, len=2.
   - Required: note_idx sequence 1,2,1,2,...; song_done never asserts.
3. Pause/resume:
   - Stimulus: pause at counter=2 with note_idx=2; wait 100 cycles; play.
   - Required: no beat_tick while paused; the next tick arrives 2 cycles after resume; note_idx goes to 3.
4. Auto-advance and wrap:
   - Stimulus: NSONGS=4, song_sel=3, auto_adv=1, GAP_BEATS=2, len=1.
   - Required: after the end tick, 2 silent ticks with mute=1, then song_sel=0, note_idx=1, PLAY.
5. Simultaneous commands:
   - Stimulus: stop and next raw edges in the same cycle during PLAY.
   - Required: IDLE, song_sel unchanged. Then tempo_div=0 and play gives a beat_tick every 2 cycles.
6. Reset mid-play:
   - Stimulus: assert reset at note_idx=5.
   - Required: all outputs at reset values within the same cycle; held button gives no pulse after reset until released and re-pressed.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song playback controller and the per-song note blocks.
// Holds the state encoding, the default field widths and the rest-note index.
package song_pkg;

    localparam int IDXW = 10;
    localparam int TDW  = 24;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // Note index 0 is silence; song note blocks output nothing for it.
    localparam logic [IDXW-1:0] REST = '0;

endpackage

// File: rtl/song_play_ctrl_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for one raw button level.
// Produces a one-cycle pulse three clk50 cycles after the raw rising edge.
module btn_edge (
    input  logic clk50,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic s_p0, s_p1, s_p2;

    // Chain resets to "pressed" so a button held through reset must be released first.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            s_p0  <= 1'b1;
            s_p1  <= 1'b1;
            s_p2  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            s_p0  <= btn;
            s_p1  <= s_p0;
            s_p2  <= s_p1;
            pulse <= s_p1 & ~s_p2;
        end
    end

endmodule

// File: rtl/song_play_ctrl.sv
// Playback sequencer: beat enable, note index and play/pause/stop/next transport
// for NSONGS songs sharing one tone output.
module song_play_ctrl #(
    parameter int NSONGS    = 4,
    parameter int IDXW      = song_pkg::IDXW,
    parameter int GAP_BEATS = 8,
    parameter int TDW       = song_pkg::TDW,
    localparam int SW       = (NSONGS > 2) ? $clog2(NSONGS) : 1
) (
    input  logic                   clk50,
    input  logic                   reset,
    input  logic                   btn_play,
    input  logic                   btn_stop,
    input  logic                   btn_next,
    input  logic                   loop_en,
    input  logic                   auto_adv,
    input  logic [TDW-1:0]         tempo_div,
    input  logic [NSONGS*IDXW-1:0] song_len,
    output logic [SW-1:0]          song_sel,
    output logic [IDXW-1:0]        note_idx,
    output logic                   beat_tick,
    output logic                   playing,
    output logic                   mute,
    output logic                   song_done
);

    import song_pkg::*;

    localparam int GW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
    localparam logic [GW-1:0]   GAP_LAST   = GW'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);
    localparam logic [IDXW-1:0] NOTE_REST  = IDXW'(REST);
    localparam logic [IDXW-1:0] NOTE_FIRST = IDXW'(1);

    logic            play_p, stop_p, next_p;
    logic [1:0]      state, state_n;
    logic [SW-1:0]   sel_n;
    logic [IDXW-1:0] note_n, len_raw, len_eff;
    logic [TDW-1:0]  cnt, cnt_n, tper, tper_n, t_eff;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic            tick_n, done_n, wrap;

    btn_edge u_play (.clk50(clk50), .reset(reset), .btn(btn_play), .pulse(play_p));
    btn_edge u_stop (.clk50(clk50), .reset(reset), .btn(btn_stop), .pulse(stop_p));
    btn_edge u_next (.clk50(clk50), .reset(reset), .btn(btn_next), .pulse(next_p));

    function automatic logic [SW-1:0] song_inc(input logic [SW-1:0] s);
        return (s == SW'(NSONGS - 1)) ? '0 : s + SW'(1);
    endfunction

    always_comb begin
        len_raw = song_len[int'(song_sel)*IDXW +: IDXW];
        len_eff = (len_raw == '0) ? NOTE_FIRST : len_raw;
        t_eff   = (tempo_div < TDW'(2)) ? TDW'(2) : tempo_div;
        // >= rather than == so a shorter tempo picked up on resume still wraps.
        wrap    = (cnt >= tper - TDW'(1));
    end

    always_comb begin
        state_n = state;
        sel_n   = song_sel;
        note_n  = note_idx;
        cnt_n   = cnt;
        tper_n  = tper;
        gap_n   = gap_cnt;
        tick_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (play_p) begin
                    state_n = ST_PLAY;
                    note_n  = NOTE_FIRST;
                    tper_n  = t_eff;
                end
            end
            ST_PLAY: begin
                if (play_p) begin
                    state_n = ST_PAUSE;
                end else if (wrap) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    tper_n = t_eff;
                    if (note_idx < len_eff) begin
                        note_n = note_idx + IDXW'(1);
                    end else if (loop_en) begin
                        note_n = NOTE_FIRST;
                    end else begin
                        done_n  = 1'b1;
                        note_n  = NOTE_REST;
                        gap_n   = '0;
                        state_n = auto_adv ? ST_GAP : ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + TDW'(1);
                end
            end
            ST_PAUSE: begin
                if (play_p) begin
                    state_n = ST_PLAY;
                    tper_n  = t_eff;
                end
            end
            default: begin
                if (GAP_BEATS == 0) begin
                    state_n = ST_PLAY;
                    sel_n   = song_inc(song_sel);
                    note_n  = NOTE_FIRST;
                    cnt_n   = '0;
                    tper_n  = t_eff;
                end else if (wrap) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    tper_n = t_eff;
                    if (gap_cnt == GAP_LAST) begin
                        state_n = ST_PLAY;
                        sel_n   = song_inc(song_sel);
                        note_n  = NOTE_FIRST;
                    end else begin
                        gap_n = gap_cnt + GW'(1);
                    end
                end else begin
                    cnt_n = cnt + TDW'(1);
                end
            end
        endcase

        // Transport overrides, stop winning over next winning over play.
        if (next_p) begin
            sel_n  = song_inc(song_sel);
            tick_n = 1'b0;
            done_n = 1'b0;
            cnt_n  = '0;
            if (state == ST_IDLE) begin
                state_n = ST_IDLE;
                note_n  = NOTE_REST;
            end else begin
                state_n = ST_PLAY;
                note_n  = NOTE_FIRST;
                tper_n  = t_eff;
            end
        end
        if (stop_p) begin
            state_n = ST_IDLE;
            sel_n   = song_sel;
            note_n  = NOTE_REST;
            cnt_n   = '0;
            gap_n   = '0;
            tick_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            song_sel  <= '0;
            note_idx  <= NOTE_REST;
            cnt       <= '0;
            gap_cnt   <= '0;
            beat_tick <= 1'b0;
            song_done <= 1'b0;
            playing   <= 1'b0;
            mute      <= 1'b1;
        end else begin
            state     <= state_n;
            song_sel  <= sel_n;
            note_idx  <= note_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_n;
            beat_tick <= tick_n;
            song_done <= done_n;
            playing   <= (state_n == ST_PLAY);
            mute      <= (state_n != ST_PLAY);
        end
    end

    // Beat period is only consulted after it has been loaded on entry to PLAY.
    always_ff @(posedge clk50) begin
        tper <= tper_n;
    end

endmodule
